// File: rtl/phys_regfile.sv
// Physical register file with integrated ready-bit scoreboard; entry 0 is hardwired to zero/ready.
// Optional macro PHYS_REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module phys_regfile #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 64,
   parameter int NREAD  = 6,
   parameter int NWRITE = 2,
   parameter int NALLOC = 3,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [NREAD*AW-1:0]     r_addr_i,
   output logic [NREAD*WIDTH-1:0]  r_data_o,
   output logic [NREAD-1:0]        r_ready_o,
   input  logic [NWRITE-1:0]       w_en_i,
   input  logic [NWRITE*AW-1:0]    w_addr_i,
   input  logic [NWRITE*WIDTH-1:0] w_data_i,
   input  logic [NALLOC-1:0]       alloc_en_i,
   input  logic [NALLOC*AW-1:0]    alloc_addr_i,
   output logic [AW:0]             ready_cnt_o
);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH-1:0] ready_q;
   logic [DEPTH-1:0] ready_d;
   logic [AW:0]      ready_cnt_q;
   logic [AW:0]      ready_cnt_d;

   // NOTE: blocking assignments here; every output gets a default first so no latch is inferred.
   always_comb begin
      data_d  = data_q;
      ready_d = ready_q;
      for (int k = 0; k < NWRITE; k++) begin
         if (w_en_i[k]) begin
            data_d[w_addr_i[k*AW +: AW]]  = w_data_i[k*WIDTH +: WIDTH];
            ready_d[w_addr_i[k*AW +: AW]] = 1'b1;
         end
      end
      // Allocations follow the writes so they win a same-address collision.
      for (int j = 0; j < NALLOC; j++) begin
         if (alloc_en_i[j]) begin
            ready_d[alloc_addr_i[j*AW +: AW]] = 1'b0;
         end
      end
      data_d[0]  = '0;
      ready_d[0] = 1'b1;
      ready_cnt_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ready_cnt_d = ready_cnt_d + (AW+1)'(ready_d[i]);
      end
   end

   // NOTE: the data array is reset in full because never-written entries must read as 0.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
         end
         ready_q     <= '1;
         ready_cnt_q <= (AW+1)'(DEPTH);
      end else begin
         data_q      <= data_d;
         ready_q     <= ready_d;
         ready_cnt_q <= ready_cnt_d;
      end
   end

   always_comb begin
      r_data_o  = '0;
      r_ready_o = '0;
      for (int n = 0; n < NREAD; n++) begin
         r_data_o[n*WIDTH +: WIDTH] = data_q[r_addr_i[n*AW +: AW]];
         r_ready_o[n]               = ready_q[r_addr_i[n*AW +: AW]];
`ifdef PHYS_REGFILE_BYPASS_EN
         for (int k = 0; k < NWRITE; k++) begin
            if (w_en_i[k] && (w_addr_i[k*AW +: AW] == r_addr_i[n*AW +: AW]) &&
                (w_addr_i[k*AW +: AW] != '0)) begin
               r_data_o[n*WIDTH +: WIDTH] = w_data_i[k*WIDTH +: WIDTH];
               r_ready_o[n]               = 1'b1;
            end
         end
`endif
      end
   end

   assign ready_cnt_o = ready_cnt_q;

endmodule

// File: tb/tb_phys_regfile.sv
// Self-checking bench for phys_regfile: directed scenarios, then randomized traffic
// compared against a per-register behavioural model.
module tb_phys_regfile;
   localparam int WIDTH  = 32;
   localparam int DEPTH  = 64;
   localparam int NREAD  = 6;
   localparam int NWRITE = 2;
   localparam int NALLOC = 3;
   localparam int AW     = $clog2(DEPTH);

   logic                    clk_i;
   logic                    reset_i;
   logic [NREAD*AW-1:0]     r_addr_i;
   logic [NREAD*WIDTH-1:0]  r_data_o;
   logic [NREAD-1:0]        r_ready_o;
   logic [NWRITE-1:0]       w_en_i;
   logic [NWRITE*AW-1:0]    w_addr_i;
   logic [NWRITE*WIDTH-1:0] w_data_i;
   logic [NALLOC-1:0]       alloc_en_i;
   logic [NALLOC*AW-1:0]    alloc_addr_i;
   logic [AW:0]             ready_cnt_o;

   int n_cmp = 0;
   int n_err = 0;

   logic [WIDTH-1:0] m_data [DEPTH];
   bit               m_ready [DEPTH];

   phys_regfile #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD), .NWRITE(NWRITE), .NALLOC(NALLOC)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .r_addr_i(r_addr_i), .r_data_o(r_data_o), .r_ready_o(r_ready_o),
      .w_en_i(w_en_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
      .alloc_en_i(alloc_en_i), .alloc_addr_i(alloc_addr_i),
      .ready_cnt_o(ready_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      w_en_i       = '0;
      w_addr_i     = '0;
      w_data_i     = '0;
      alloc_en_i   = '0;
      alloc_addr_i = '0;
   endtask

   task automatic set_write(input int k, input int a, input logic [WIDTH-1:0] d);
      w_en_i[k]                = 1'b1;
      w_addr_i[k*AW +: AW]     = AW'(a);
      w_data_i[k*WIDTH +: WIDTH] = d;
   endtask

   task automatic set_alloc(input int j, input int a);
      alloc_en_i[j]            = 1'b1;
      alloc_addr_i[j*AW +: AW] = AW'(a);
   endtask

   task automatic set_read(input int n, input int a);
      r_addr_i[n*AW +: AW] = AW'(a);
   endtask

   function automatic int model_count();
      int c = 0;
      for (int a = 0; a < DEPTH; a++) c += int'(m_ready[a]);
      return c;
   endfunction

   // Expected read for register a given the stored model and this cycle's inputs.
   task automatic exp_read(input int a, output logic [WIDTH-1:0] d, output logic r);
      if (a == 0) begin
         d = '0;
         r = 1'b1;
      end else begin
         d = m_data[a];
         r = m_ready[a];
`ifdef PHYS_REGFILE_BYPASS_EN
         for (int k = 0; k < NWRITE; k++) begin
            if (w_en_i[k] && int'(w_addr_i[k*AW +: AW]) == a) begin
               d = w_data_i[k*WIDTH +: WIDTH];
               r = 1'b1;
            end
         end
`endif
      end
   endtask

   task automatic check_reads(input string tag);
      for (int n = 0; n < NREAD; n++) begin
         logic [WIDTH-1:0] ed;
         logic             er;
         exp_read(int'(r_addr_i[n*AW +: AW]), ed, er);
         check($sformatf("%s_p%0d_data", tag, n), 64'(r_data_o[n*WIDTH +: WIDTH]), 64'(ed));
         check($sformatf("%s_p%0d_rdy", tag, n), 64'(r_ready_o[n]), 64'(er));
      end
   endtask

   // Apply the clock edge to the model: per register, decide written / allocated.
   task automatic model_edge();
      if (reset_i) begin
         for (int a = 0; a < DEPTH; a++) begin
            m_data[a]  = '0;
            m_ready[a] = 1'b1;
         end
      end else begin
         for (int a = 1; a < DEPTH; a++) begin
            bit               wr = 1'b0;
            bit               al = 1'b0;
            logic [WIDTH-1:0] v  = '0;
            for (int k = 0; k < NWRITE; k++)
               if (w_en_i[k] && int'(w_addr_i[k*AW +: AW]) == a) begin
                  wr = 1'b1;
                  v  = w_data_i[k*WIDTH +: WIDTH];
               end
            for (int j = 0; j < NALLOC; j++)
               if (alloc_en_i[j] && int'(alloc_addr_i[j*AW +: AW]) == a) al = 1'b1;
            if (wr) m_data[a] = v;
            if (al) m_ready[a] = 1'b0;
            else if (wr) m_ready[a] = 1'b1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      model_edge();
      #1;
      clear_inputs();
      reset_i = 1'b0;
   endtask

   function automatic int rand_addr();
      return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH-1))
                                         : int'($urandom_range(0, 15));
   endfunction

   initial begin
      for (int a = 0; a < DEPTH; a++) begin
         m_data[a]  = 'x;
         m_ready[a] = 1'b0;
      end
      clear_inputs();
      r_addr_i = '0;
      reset_i  = 1'b1;
      // Pending write/alloc during reset must be discarded.
      set_write(0, 4, 32'h5555_AAAA);
      set_alloc(0, 6);
      tick();

      check("reset_cnt", 64'(ready_cnt_o), 64'(DEPTH));
      set_read(0, 0); set_read(1, 1); set_read(2, DEPTH-1);
      set_read(3, 4); set_read(4, 6); set_read(5, DEPTH-1);
      #1;
      check("reset_a1_data", 64'(r_data_o[1*WIDTH +: WIDTH]), 64'h0);
      check("reset_a63_rdy", 64'(r_ready_o[2]), 64'h1);
      check_reads("reset");

      set_alloc(0, 5);
      tick();
      set_read(0, 5);
      #1;
      check("alloc5_rdy", 64'(r_ready_o[0]), 64'h0);
      check("alloc5_cnt", 64'(ready_cnt_o), 64'(DEPTH-1));
      set_write(1, 5, 32'hDEAD_BEEF);
      tick();
      #1;
      check("write5_data", 64'(r_data_o[0 +: WIDTH]), 64'hDEAD_BEEF);
      check("write5_rdy", 64'(r_ready_o[0]), 64'h1);
      check("write5_cnt", 64'(ready_cnt_o), 64'(DEPTH));

      set_write(0, 0, 32'h1234);
      set_alloc(2, 0);
      set_read(1, 0);
      tick();
      #1;
      check("zero_data", 64'(r_data_o[1*WIDTH +: WIDTH]), 64'h0);
      check("zero_rdy", 64'(r_ready_o[1]), 64'h1);
      check("zero_cnt", 64'(ready_cnt_o), 64'(DEPTH));

      set_write(0, 9, 32'h11);
      set_write(1, 9, 32'h22);
      tick();
      set_read(2, 9);
      #1;
      check("dual9_data", 64'(r_data_o[2*WIDTH +: WIDTH]), 64'h22);

      set_write(0, 7, 32'h77);
      set_alloc(1, 7);
      tick();
      set_read(3, 7);
      #1;
      check("coll7_data", 64'(r_data_o[3*WIDTH +: WIDTH]), 64'h77);
      check("coll7_rdy", 64'(r_ready_o[3]), 64'h0);
      check("coll7_cnt", 64'(ready_cnt_o), 64'(DEPTH-1));

      set_write(1, 3, 32'hAB);
      set_read(4, 3);
      #1;
`ifdef PHYS_REGFILE_BYPASS_EN
      check("byp3_same_data", 64'(r_data_o[4*WIDTH +: WIDTH]), 64'hAB);
`else
      check("byp3_same_data", 64'(r_data_o[4*WIDTH +: WIDTH]), 64'h0);
`endif
      check("byp3_same_rdy", 64'(r_ready_o[4]), 64'h1);
      check_reads("byp3");
      tick();
      #1;
      check("byp3_next_data", 64'(r_data_o[4*WIDTH +: WIDTH]), 64'hAB);

      // Randomized traffic with collisions, duplicates and occasional reset.
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < NWRITE; k++)
            if ($urandom_range(0, 1) == 1) set_write(k, rand_addr(), WIDTH'($urandom));
         for (int j = 0; j < NALLOC; j++)
            if ($urandom_range(0, 2) == 0) set_alloc(j, rand_addr());
         for (int n = 0; n < NREAD; n++) set_read(n, rand_addr());
         reset_i = ($urandom_range(0, 59) == 0);
         #1;
         check_reads($sformatf("rnd%0d", c));
         tick();
         check($sformatf("rnd%0d_cnt", c), 64'(ready_cnt_o), 64'(model_count()));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
